// File: rtl/rs_error_injector.sv
// Frame-aware error injector for RS codec benches: tracks N-symbol frames on an
// active-low sync level and XORs slot-programmed magnitudes into chosen symbols.

module rs_err_slot #(
  parameter int SYM_W = 8,
  parameter int N     = 255,
  parameter int POS_W = 8
) (
  input  logic             en,
  input  logic [POS_W-1:0] pos,
  input  logic [SYM_W-1:0] mag,
  input  logic [POS_W-1:0] off,
  input  logic             rot,
  input  logic [POS_W-1:0] sym_cnt,
  output logic [SYM_W-1:0] hit_mag
);
  logic [POS_W:0] sum, eff;

  // pos and off are both below N, so one conditional subtract wraps the rotation
  always_comb begin
    sum = {1'b0, pos} + (rot ? {1'b0, off} : '0);
    eff = (sum >= (POS_W+1)'(N)) ? sum - (POS_W+1)'(N) : sum;
  end

  assign hit_mag = (en && ({1'b0, pos} < (POS_W+1)'(N)) && (eff == {1'b0, sym_cnt})) ? mag : '0;
endmodule

module rs_error_injector #(
  parameter int SYM_W   = 8,
  parameter int N       = 255,
  parameter int K       = 239,
  parameter int MAX_ERR = 8,
  parameter int POS_W   = 8,
  parameter int FCNT_W  = 16,
  localparam int IDX_W  = (MAX_ERR > 1) ? $clog2(MAX_ERR) : 1
) (
  input  logic              clk_in,
  input  logic              sys_rst_n,
  input  logic              sync_in,
  input  logic [SYM_W-1:0]  data_in,
  input  logic [1:0]        mode,
  input  logic              arm,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic              cfg_en,
  input  logic [POS_W-1:0]  cfg_pos,
  input  logic [SYM_W-1:0]  cfg_mag,
  output logic              sync_out,
  output logic [SYM_W-1:0]  data_out,
  output logic              sof_out,
  output logic              eof_out,
  output logic              err_flag,
  output logic              frame_abort,
  output logic [POS_W-1:0]  inj_cnt,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              shot_done
);
  if (K >= N || (1 << POS_W) < N) begin : g_bad_params
    $error("rs_error_injector: need K < N and 2**POS_W >= N");
  end

  localparam logic [POS_W-1:0] LAST = POS_W'(N - 1);

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic             en;
    logic [POS_W-1:0] pos;
    logic [SYM_W-1:0] mag;
  } slot_t;

  state_t                          state, state_nxt;
  slot_t [MAX_ERR-1:0]             shadow, shadow_nxt, active;
  logic  [MAX_ERR-1:0][SYM_W-1:0]  hit_mag;
  logic  [POS_W-1:0]               sym_cnt, off, inj_acc;
  logic  [SYM_W-1:0]               mask;
  logic  [1:0]                     mode_q;
  logic                            armed, shot_active, arm_ok, inj_en;
  logic                            frame_start, eof, abort;

  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    eof         = 1'b0;
    abort       = 1'b0;
    case (state)
      IDLE: if (!sync_in) begin
        state_nxt   = RUN;
        frame_start = 1'b1;
      end
      RUN: begin
        if (sym_cnt == LAST) begin
          eof = 1'b1;
          if (sync_in) state_nxt = IDLE;
          else         frame_start = 1'b1;
        end else if (sync_in) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // merging the write here lets a same-cycle write reach the frame-start copy
  always_comb begin
    shadow_nxt = shadow;
    for (int i = 0; i < MAX_ERR; i++)
      if (cfg_we && cfg_idx == IDX_W'(i)) shadow_nxt[i] = '{cfg_en, cfg_pos, cfg_mag};
  end

  for (genvar g = 0; g < MAX_ERR; g++) begin : g_slot
    rs_err_slot #(.SYM_W(SYM_W), .N(N), .POS_W(POS_W)) u_slot (
      .en      (active[g].en),
      .pos     (active[g].pos),
      .mag     (active[g].mag),
      .off     (off),
      .rot     (mode_q == 2'd3),
      .sym_cnt (sym_cnt),
      .hit_mag (hit_mag[g])
    );
  end

  always_comb begin
    inj_en = (state == RUN) &&
             ((mode_q == 2'd1) || (mode_q == 2'd3) || ((mode_q == 2'd2) && shot_active));
    mask = '0;
    for (int i = 0; i < MAX_ERR; i++) mask = mask ^ hit_mag[i];
    if (!inj_en) mask = '0;
  end

  assign arm_ok = arm && !armed && !shot_active;

  always_ff @(posedge clk_in) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      shadow      <= '0;
      active      <= '0;
      sym_cnt     <= '0;
      off         <= '0;
      inj_acc     <= '0;
      mode_q      <= 2'd0;
      armed       <= 1'b0;
      shot_active <= 1'b0;
      sync_out    <= 1'b1;
      data_out    <= '0;
      sof_out     <= 1'b0;
      eof_out     <= 1'b0;
      err_flag    <= 1'b0;
      frame_abort <= 1'b0;
      inj_cnt     <= '0;
      frame_cnt   <= '0;
      shot_done   <= 1'b0;
    end else begin
      state       <= state_nxt;
      shadow      <= shadow_nxt;
      sync_out    <= sync_in;
      data_out    <= data_in ^ mask;
      err_flag    <= |mask;
      sof_out     <= (state == RUN) && (sym_cnt == '0);
      eof_out     <= eof;
      frame_abort <= abort;

      if (state == RUN) begin
        sym_cnt <= sym_cnt + POS_W'(1);
        if (|mask) inj_acc <= inj_acc + POS_W'(1);
      end

      if (eof) begin
        inj_cnt   <= inj_acc + POS_W'(|mask);
        frame_cnt <= frame_cnt + FCNT_W'(1);
        off       <= (off == LAST) ? '0 : off + POS_W'(1);
        if (shot_active) begin
          shot_done   <= 1'b1;
          shot_active <= 1'b0;
        end
      end

      if (abort) shot_active <= 1'b0;

      if (arm_ok) begin
        armed     <= 1'b1;
        shot_done <= 1'b0;
      end

      // later assignments win: frame start overrides the eof/idle updates above
      if (frame_start) begin
        sym_cnt <= '0;
        inj_acc <= '0;
        active  <= shadow_nxt;
        mode_q  <= mode;
        if (mode == 2'd3 && mode_q != 2'd3) off <= '0;
        if (mode == 2'd2 && armed) begin
          shot_active <= 1'b1;
          armed       <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_rs_error_injector.sv
// Directed bench for rs_error_injector: bypass, fixed, single-shot, rotate,
// cancelling/out-of-range slots, abort and mid-frame reset.

module tb_rs_error_injector;
  localparam int SYM_W = 8, N = 255, K = 239, MAX_ERR = 8, POS_W = 9, FCNT_W = 16;

  logic              clk = 1'b0;
  logic              sys_rst_n, sync_in, arm, cfg_we, cfg_en;
  logic [SYM_W-1:0]  data_in, cfg_mag;
  logic [1:0]        mode;
  logic [2:0]        cfg_idx;
  logic [POS_W-1:0]  cfg_pos;
  logic              sync_out, sof_out, eof_out, err_flag, frame_abort, shot_done;
  logic [SYM_W-1:0]  data_out;
  logic [POS_W-1:0]  inj_cnt;
  logic [FCNT_W-1:0] frame_cnt;

  logic [7:0] sym   [0:N-1];
  logic [7:0] emask [0:N-1];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  rs_error_injector #(.SYM_W(SYM_W), .N(N), .K(K), .MAX_ERR(MAX_ERR), .POS_W(POS_W), .FCNT_W(FCNT_W)) dut (
    .clk_in(clk), .sys_rst_n(sys_rst_n), .sync_in(sync_in), .data_in(data_in), .mode(mode),
    .arm(arm), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_pos(cfg_pos),
    .cfg_mag(cfg_mag), .sync_out(sync_out), .data_out(data_out), .sof_out(sof_out),
    .eof_out(eof_out), .err_flag(err_flag), .frame_abort(frame_abort), .inj_cnt(inj_cnt),
    .frame_cnt(frame_cnt), .shot_done(shot_done));

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int idx, input logic en, input int pos, input int mag);
    cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_en = en; cfg_pos = POS_W'(pos); cfg_mag = 8'(mag);
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic pattern();
    for (int i = 0; i < N; i++) begin
      sym[i]   = 8'(i * 37 + 11);
      emask[i] = 8'h00;
    end
  endtask

  task automatic lead(input string tag);
    sync_in = 1'b0; data_in = 8'h00;
    cyc();
    chk({tag, " lead_sof"}, 32'(sof_out), 0);
  endtask

  task automatic syms(input string tag, input int first, input int last, input bit end_high);
    for (int i = first; i <= last; i++) begin
      sync_in = (i == last) && end_high;
      data_in = sym[i];
      cyc();
      chk($sformatf("%s data@%0d", tag, i), 32'(data_out), 32'(sym[i] ^ emask[i]));
      chk($sformatf("%s err@%0d", tag, i), 32'(err_flag), 32'(emask[i] != 8'h00));
      chk($sformatf("%s sof@%0d", tag, i), 32'(sof_out), 32'(i == 0));
      chk($sformatf("%s eof@%0d", tag, i), 32'(eof_out), 32'(i == N - 1));
      chk($sformatf("%s sync@%0d", tag, i), 32'(sync_out), 32'(sync_in));
    end
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, " sync_out"}, 32'(sync_out), 1);
    chk({tag, " data_out"}, 32'(data_out), 0);
    chk({tag, " sof"}, 32'(sof_out), 0);
    chk({tag, " eof"}, 32'(eof_out), 0);
    chk({tag, " err"}, 32'(err_flag), 0);
    chk({tag, " abort"}, 32'(frame_abort), 0);
    chk({tag, " inj_cnt"}, 32'(inj_cnt), 0);
    chk({tag, " frame_cnt"}, 32'(frame_cnt), 0);
    chk({tag, " shot_done"}, 32'(shot_done), 0);
  endtask

  initial begin
    sys_rst_n = 1'b0; sync_in = 1'b0; data_in = 8'hA5; mode = 2'd0; arm = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_pos = '0; cfg_mag = '0;
    cyc(); cyc();
    rst_chk("reset");
    sys_rst_n = 1'b1; sync_in = 1'b1;
    cyc();

    // bypass
    for (int i = 0; i < N; i++) begin sym[i] = 8'h00; emask[i] = 8'h00; end
    sym[N-1] = 8'd185;
    lead("byp"); syms("byp", 0, N-1, 1'b1);
    chk("byp frame_cnt", 32'(frame_cnt), 1);
    chk("byp inj_cnt", 32'(inj_cnt), 0);

    // fixed, three back-to-back frames
    pattern();
    sym[239] = 8'd185; sym[253] = 8'd232;
    emask[239] = 8'h01; emask[253] = 8'h01;
    wr(0, 1'b1, 239, 1); wr(1, 1'b1, 253, 1);
    mode = 2'd1;
    lead("fix1"); syms("fix1", 0, N-1, 1'b0);
    chk("fix1 inj_cnt", 32'(inj_cnt), 2);
    chk("fix1 frame_cnt", 32'(frame_cnt), 2);
    syms("fix2", 0, N-1, 1'b0);
    chk("fix2 inj_cnt", 32'(inj_cnt), 2);
    syms("fix3", 0, N-1, 1'b1);
    chk("fix3 inj_cnt", 32'(inj_cnt), 2);
    chk("fix3 frame_cnt", 32'(frame_cnt), 4);

    // single shot
    pattern();
    wr(0, 1'b1, 9, 6); wr(1, 1'b0, 0, 0);
    mode = 2'd2;
    arm = 1'b1; cyc(); arm = 1'b0;
    chk("shot pre_done", 32'(shot_done), 0);
    emask[9] = 8'h06;
    lead("shot1"); syms("shot1", 0, N-1, 1'b0);
    chk("shot1 done", 32'(shot_done), 1);
    chk("shot1 inj_cnt", 32'(inj_cnt), 1);
    emask[9] = 8'h00;
    syms("shot2", 0, N-1, 1'b1);
    chk("shot2 inj_cnt", 32'(inj_cnt), 0);
    chk("shot2 done", 32'(shot_done), 1);
    arm = 1'b1; cyc(); arm = 1'b0;
    chk("shot rearm_clears", 32'(shot_done), 0);

    // rotate
    pattern();
    wr(0, 1'b1, 254, 8'h0F);
    mode = 2'd3;
    emask[254] = 8'h0F;
    lead("rot1"); syms("rot1", 0, N-1, 1'b0);
    emask[254] = 8'h00; emask[0] = 8'h0F;
    syms("rot2", 0, N-1, 1'b0);
    emask[0] = 8'h00; emask[1] = 8'h0F;
    syms("rot3", 0, N-1, 1'b1);
    chk("rot3 inj_cnt", 32'(inj_cnt), 1);
    chk("rot3 frame_cnt", 32'(frame_cnt), 9);

    // cancelling duplicates, out-of-range positions, zero magnitude
    pattern();
    wr(0, 1'b1, 5, 8'h33); wr(1, 1'b1, 5, 8'h33);
    wr(2, 1'b1, 300, 8'hFF); wr(3, 1'b1, 255, 8'h11); wr(4, 1'b1, 7, 8'h00);
    mode = 2'd1;
    lead("dup"); syms("dup", 0, N-1, 1'b1);
    chk("dup inj_cnt", 32'(inj_cnt), 0);
    chk("dup frame_cnt", 32'(frame_cnt), 10);

    // abort at symbol 100
    wr(5, 1'b1, 50, 8'h80);
    emask[50] = 8'h80;
    lead("abt"); syms("abt", 0, 99, 1'b0);
    sync_in = 1'b1; data_in = sym[100];
    cyc();
    chk("abt pulse", 32'(frame_abort), 1);
    chk("abt eof", 32'(eof_out), 0);
    cyc();
    chk("abt pulse_end", 32'(frame_abort), 0);
    chk("abt frame_cnt", 32'(frame_cnt), 10);
    chk("abt inj_cnt", 32'(inj_cnt), 0);

    // reset at symbol 50, then a frame proving slots were cleared
    lead("rst"); syms("rst", 0, 49, 1'b0);
    sys_rst_n = 1'b0; sync_in = 1'b0; data_in = sym[50];
    cyc();
    rst_chk("midrst");
    sys_rst_n = 1'b1; sync_in = 1'b1;
    cyc();
    mode = 2'd1;
    emask[50] = 8'h00;
    lead("post"); syms("post", 0, N-1, 1'b1);
    chk("post inj_cnt", 32'(inj_cnt), 0);
    chk("post frame_cnt", 32'(frame_cnt), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rs_error_injector.md
Name: rs_error_injector

Overview:
- Parametrised, synthesizable error-injection stage between an RS encoder (or fixed-pattern source) and RSdecoder.
- Tracks N-symbol frames delimited by an active-low sync level and XORs programmable error magnitudes into programmable symbol positions.
- Replaces hand-edited corrupted-symbol stimulus with register-configured error patterns: fixed, single-shot or rotating.
- Emits a 1-cycle-delayed, aligned stream plus frame and injection status for self-checking benches.

Parameters:
SYM_W, 8, symbol width in bits
N, 255, codeword length in symbols
K, 239, message length in symbols (status only: parity region = positions K..N-1)
MAX_ERR, 8, number of error slots; (N-K)/2 = correction capability t
POS_W, 8, symbol position / counter width; must satisfy 2^POS_W >= N
FCNT_W, 16, frame counter width

Ports:
clk_in  in  1  system clock, all logic rising-edge
sys_rst_n  in  1  synchronous active-low reset
sync_in  in  1  active-low frame level; high = idle
data_in  in  SYM_W  input symbol
mode  in  2  0 bypass, 1 fixed, 2 single-shot, 3 rotate
arm  in  1  single-cycle pulse; arms one single-shot frame
cfg_we  in  1  slot write strobe
cfg_idx  in  clog2(MAX_ERR)  slot index
cfg_en  in  1  slot enable
cfg_pos  in  POS_W  slot symbol position
cfg_mag  in  SYM_W  slot XOR magnitude
sync_out  out  1  sync_in delayed 1 cycle
data_out  out  SYM_W  possibly corrupted symbol
sof_out  out  1  high with symbol 0 on data_out
eof_out  out  1  high with symbol N-1 on data_out
err_flag  out  1  data_out differs from its input symbol
frame_abort  out  1  1-cycle pulse: frame cut short
inj_cnt  out  POS_W  corrupted-symbol count of last completed frame
frame_cnt  out  FCNT_W  completed frames, wraps
shot_done  out  1  single-shot frame completed; cleared by arm

Behaviour:
- Reset (sys_rst_n low at an edge): state IDLE, counters 0. Outputs: sync_out=1, data_out=0, sof_out=0, eof_out=0, err_flag=0, frame_abort=0, inj_cnt=0, frame_cnt=0, shot_done=0. Slots cleared: en=0, pos=0, mag=0. Armed flag and rotate offset cleared. Reset mid-frame discards the frame; no eof, abort or count.
- FSM IDLE: sync_in sampled low -> RUN, sym_cnt=0; the next data_in sample is symbol 0.
- FSM RUN: each edge samples data_in as symbol sym_cnt.
  - sync_in sampled high with sym_cnt < N-1 -> frame_abort pulse, counters unchanged, -> IDLE.
  - At sym_cnt=N-1: eof asserted. If sync_in is still low -> sym_cnt=0, back-to-back next frame. Otherwise -> IDLE.
- Latency: exactly 1 cycle on data_out, sync_out and all flags. Mode 0 gives bit-exact pass-through with err_flag=0.
- Config timing: cfg_we writes a shadow slot at any time. Shadow copies to active slots only at frame start (entering RUN or sym_cnt wrap to 0). A write in the same cycle as that copy is included. mode is sampled at frame start and held for the frame.
- Corruption: mask = XOR of mag over enabled slots whose effective position == sym_cnt.
  - Duplicate positions XOR together; identical magnitudes cancel and give err_flag=0.
  - mag=0 is not an injection.
  - Positions >= N never fire.
  - err_flag = (mask != 0).
- Effective position:
  - Modes 1 and 2: pos.
  - Mode 3: pos + off, minus N if >= N. off increments at each completed frame and wraps N-1 -> 0. off resets to 0 on reset or on entering mode 3.
- Single-shot (mode 2): injects only in the first frame starting while armed. Armed clears at that frame start. shot_done sets at that frame's eof. arm while a shot is pending is ignored.
- At eof: inj_cnt <= corrupted symbols in the frame; frame_cnt += 1, wrapping at 2^FCNT_W. Aborted frames update neither.

Test Plan:
- N=255, mode 0, sync low, 254 zero symbols then 185 -> data_out equals data_in 1 cycle later. sof_out with symbol 0, eof_out with 185, err_flag never high, frame_cnt=1.
- Mode 1, slot0 pos=239 mag=1, slot1 pos=253 mag=1, three back-to-back frames with symbols 239,253 = 185,232 -> outputs 184,233 in every frame. err_flag high on those two symbols only, inj_cnt=2, frame_cnt=3.
- Mode 2, slot0 pos=9 mag=6, arm, two frames -> first frame symbol 9 XOR 6 and shot_done=1 at its eof. Second frame clean, inj_cnt=0.
- Mode 3, slot0 pos=254 mag=0x0F, three frames -> corrupted symbol at 254, then 0, then 1 (wrap).
- Slots 0 and 1 both pos=5 mag=0x33 -> symbol 5 unchanged, err_flag=0, inj_cnt=0. Slot pos=300 with POS_W=9 -> no injection.
- sync_in high at sym_cnt=100 -> frame_abort pulse, frame_cnt unchanged. sys_rst_n low at sym_cnt=50 -> all outputs at reset values next cycle, slots cleared.
